// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: framed serial-to-parallel receiver with parity,
// stop-bit checking and a valid/ready output register.
// Optional feature macro: SERIAL_RX_ERROR_COUNT_EN (adds ERROR_COUNT).
//
// Handshake: DATA_VALID rises when a frame loads and stays high, with data
// and flags stable, until a cycle where DATA_VALID & DATA_READY are both 1.
// DATA_VALID drops after that cycle unless another frame loads on the same edge.
module serial_frame_receiver #(
   parameter int DATA_WIDTH    = 8,
   parameter int PARITY_MODE   = 1,
   parameter int STOP_BITS     = 1,
   parameter int LSB_FIRST     = 1,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                  CONTROL_CLOCK,
   input  logic                  RESET,
   input  logic                  BIT_STROBE,
   input  logic                  DEBOUNCED_DATA,
   output logic [DATA_WIDTH-1:0] PARALLEL_DATA_OUTPUT,
   output logic                  DATA_VALID,
   input  logic                  DATA_READY,
   output logic                  PARITY_ERROR,
   output logic                  FRAME_ERROR,
   output logic                  OVERRUN,
   output logic                  BUSY
`ifdef SERIAL_RX_ERROR_COUNT_EN
   ,
   output logic [ERR_CNT_WIDTH-1:0] ERROR_COUNT
`endif
);

   localparam int CNT_W  = 5;
   localparam int STOP_W = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_IDLE
   } state_t;

   state_t                state_q;
   logic [CNT_W-1:0]      bit_cnt_q;
   logic [STOP_W-1:0]     stop_cnt_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic                  perr_q;
   logic                  stop_err_q;

   logic [DATA_WIDTH-1:0] out_data_q;
   logic                  out_valid_q;
   logic                  out_perr_q;
   logic                  out_ferr_q;
   logic                  overrun_q;

   logic [DATA_WIDTH-1:0] shift_d;
   logic                  perr_d;
   logic                  ferr_d;
   logic                  last_stop;
   logic                  frame_done;
   logic                  accept;

   // Next shift value, parity verdict and stop-bit verdict for the current sample.
   always_comb begin
      shift_d = shift_q;
      if (LSB_FIRST != 0) begin
         // New bit enters at the top; after DATA_WIDTH bits the first bit is bit 0.
         shift_d = DATA_WIDTH'({DEBOUNCED_DATA, shift_q} >> 1);
      end else begin
         // New bit enters at the bottom; the first bit ends up at the MSB.
         shift_d = DATA_WIDTH'({shift_q, DEBOUNCED_DATA});
      end
      perr_d = 1'b0;
      if (PARITY_MODE == 1) begin
         perr_d = ~(^shift_q ^ DEBOUNCED_DATA);
      end else if (PARITY_MODE == 2) begin
         perr_d = ^shift_q ^ DEBOUNCED_DATA;
      end
      ferr_d     = stop_err_q | ~DEBOUNCED_DATA;
      last_stop  = (stop_cnt_q == STOP_W'(STOP_BITS - 1));
      frame_done = BIT_STROBE && (state_q == ST_STOP) && last_stop;
      accept     = out_valid_q && DATA_READY;
   end

   // Frame FSM plus the output register and handshake.
   always_ff @(posedge CONTROL_CLOCK) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         stop_cnt_q  <= '0;
         shift_q     <= '0;
         perr_q      <= 1'b0;
         stop_err_q  <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_perr_q  <= 1'b0;
         out_ferr_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (BIT_STROBE) begin
            case (state_q)
               ST_IDLE: begin
                  if (!DEBOUNCED_DATA) begin
                     state_q    <= ST_DATA;
                     bit_cnt_q  <= '0;
                     stop_cnt_q <= '0;
                     perr_q     <= 1'b0;
                     stop_err_q <= 1'b0;
                  end
               end
               ST_DATA: begin
                  shift_q <= shift_d;
                  if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                     state_q <= (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                  end
               end
               ST_PARITY: begin
                  perr_q  <= perr_d;
                  state_q <= ST_STOP;
               end
               ST_STOP: begin
                  if (last_stop) begin
                     state_q <= ferr_d ? ST_WAIT_IDLE : ST_IDLE;
                  end else begin
                     stop_cnt_q <= stop_cnt_q + STOP_W'(1);
                     stop_err_q <= ferr_d;
                  end
               end
               ST_WAIT_IDLE: begin
                  // A line still low after a bad stop must not look like a start bit.
                  if (DEBOUNCED_DATA) begin
                     state_q <= ST_IDLE;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end

         if (frame_done) begin
            if (!out_valid_q || DATA_READY) begin
               out_data_q  <= shift_q;
               out_perr_q  <= perr_q;
               out_ferr_q  <= ferr_d;
               out_valid_q <= 1'b1;
               if (accept) begin
                  overrun_q <= 1'b0;
               end
            end else begin
               // Consumer still holds the previous frame: drop the new one.
               overrun_q <= 1'b1;
            end
         end else if (accept) begin
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
         end
      end
   end

`ifdef SERIAL_RX_ERROR_COUNT_EN
   logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

   // Saturating count of completed frames carrying any error, dropped ones included.
   always_ff @(posedge CONTROL_CLOCK) begin
      if (RESET) begin
         err_cnt_q <= '0;
      end else if (frame_done && (perr_q || ferr_d) && (err_cnt_q != '1)) begin
         err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
      end
   end

   assign ERROR_COUNT = err_cnt_q;
`endif

   assign PARALLEL_DATA_OUTPUT = out_data_q;
   assign DATA_VALID           = out_valid_q;
   assign PARITY_ERROR         = out_perr_q;
   assign FRAME_ERROR          = out_ferr_q;
   assign OVERRUN              = overrun_q;
   assign BUSY                 = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver with a frame scoreboard.
// Define SERIAL_RX_ERROR_COUNT_EN to also exercise ERROR_COUNT saturation.
module tb_serial_frame_receiver;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         strobe;
   logic         line;
   logic         ready;
   logic [W-1:0] pdata;
   logic         valid;
   logic         perr;
   logic         ferr;
   logic         ovr;
   logic         busy;
`ifdef SERIAL_RX_ERROR_COUNT_EN
   logic [1:0]   err_cnt;
`endif

   int checks       = 0;
   int errors       = 0;
   int valid_cycles = 0;

   // Expected frames: {parity_error, frame_error, data}
   logic [W+1:0] exp_q[$];

   // clock/reset block
   always #5 clk = ~clk;

   serial_frame_receiver #(
      .DATA_WIDTH    (W),
      .PARITY_MODE   (1),
      .STOP_BITS     (1),
      .LSB_FIRST     (1),
      .ERR_CNT_WIDTH (2)
   ) dut (
      .CONTROL_CLOCK        (clk),
      .RESET                (rst),
      .BIT_STROBE           (strobe),
      .DEBOUNCED_DATA       (line),
      .PARALLEL_DATA_OUTPUT (pdata),
      .DATA_VALID           (valid),
      .DATA_READY           (ready),
      .PARITY_ERROR         (perr),
      .FRAME_ERROR          (ferr),
      .OVERRUN              (ovr),
      .BUSY                 (busy)
`ifdef SERIAL_RX_ERROR_COUNT_EN
      ,
      .ERROR_COUNT          (err_cnt)
`endif
   );

   // scoreboard: pop and compare on every accepted handshake
   always @(negedge clk) begin
      if (!rst && valid) begin
         valid_cycles++;
      end
      if (!rst && valid && ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL sb_unexpected: observed frame %h, expected no frame", {perr, ferr, pdata});
         end else begin
            logic [W+1:0] exp_v;
            exp_v = exp_q.pop_front();
            assert ({perr, ferr, pdata} === exp_v)
            else begin
               errors++;
               $error("FAIL sb_frame: observed %h expected %h", {perr, ferr, pdata}, exp_v);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // driver tasks
   task automatic drive_bit(input logic b, input logic set_ready);
      @(posedge clk);
      #1;
      strobe = 1'b1;
      line   = b;
      if (set_ready) ready = 1'b1;
      @(posedge clk);
      #1;
      strobe = 1'b0;
      line   = 1'b1;
      repeat ($urandom_range(0, 2)) @(posedge clk);
   endtask

   task automatic send_frame(input logic [W-1:0] data, input logic bad_par,
                             input logic stop_val, input logic ready_on_last);
      logic p;
      drive_bit(1'b0, 1'b0);
      for (int i = 0; i < W; i++) drive_bit(data[i], 1'b0);
      p = (~^data) ^ bad_par;
      drive_bit(p, 1'b0);
      drive_bit(stop_val, ready_on_last);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst    = 1'b1;
      strobe = 1'b0;
      line   = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst    = 1'b1;
      strobe = 1'b0;
      line   = 1'b1;
      ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_data",    32'(pdata), 32'h0);
      check("rst_valid",   32'(valid), 32'h0);
      check("rst_perr",    32'(perr),  32'h0);
      check("rst_ferr",    32'(ferr),  32'h0);
      check("rst_overrun", 32'(ovr),   32'h0);
      check("rst_busy",    32'(busy),  32'h0);

      // good frame 0x5A, consumer always ready
      valid_cycles = 0;
      exp_q.push_back({1'b0, 1'b0, 8'h5A});
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
      idle(3);
      check("t1_valid_cycles", 32'(valid_cycles), 32'd1);
      check("t1_valid_low",    32'(valid), 32'h0);
      check("t1_busy",         32'(busy),  32'h0);

      // same frame with the parity bit inverted
      exp_q.push_back({1'b1, 1'b0, 8'h5A});
      send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
      idle(3);

      // stop sampled low, line then held low for five strobes
      valid_cycles = 0;
      exp_q.push_back({1'b0, 1'b1, 8'h3C});
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("t3_busy_wait", 32'(busy), 32'h1);
      for (int i = 0; i < 5; i++) drive_bit(1'b0, 1'b0);
      idle(2);
      check("t3_busy_low_line", 32'(busy), 32'h1);
      check("t3_no_new_frame",  32'(valid_cycles), 32'd1);
      drive_bit(1'b1, 1'b0);
      @(negedge clk);
      check("t3_busy_released", 32'(busy), 32'h0);

      // overrun: consumer stalled, second frame dropped
      ready = 1'b0;
      exp_q.push_back({1'b0, 1'b0, 8'h11});
      send_frame(8'h11, 1'b0, 1'b1, 1'b0);
      send_frame(8'h22, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check("t4_valid_held", 32'(valid), 32'h1);
      check("t4_data_held",  32'(pdata), 32'h11);
      check("t4_overrun",    32'(ovr),   32'h1);
      @(posedge clk);
      #1;
      ready = 1'b1;
      idle(1);
      check("t4_valid_clr",   32'(valid), 32'h0);
      check("t4_overrun_clr", 32'(ovr),   32'h0);

      // completion on the same edge as a handshake: no overrun
      ready = 1'b0;
      exp_q.push_back({1'b0, 1'b0, 8'h33});
      send_frame(8'h33, 1'b0, 1'b1, 1'b0);
      exp_q.push_back({1'b0, 1'b0, 8'hC4});
      send_frame(8'hC4, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      check("t7_overrun_none", 32'(ovr), 32'h0);
      idle(3);
      check("t7_valid_clr", 32'(valid), 32'h0);
      check("t7_last_data", 32'(pdata), 32'hC4);

      // reset after four data bits, then a clean frame
      drive_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(i[0], 1'b0);
      do_reset();
      @(negedge clk);
      check("t5_data",  32'(pdata), 32'h0);
      check("t5_valid", 32'(valid), 32'h0);
      check("t5_busy",  32'(busy),  32'h0);
      check("t5_ovr",   32'(ovr),   32'h0);
`ifdef SERIAL_RX_ERROR_COUNT_EN
      check("t5_err_cnt", 32'(err_cnt), 32'h0);
`endif
      exp_q.push_back({1'b0, 1'b0, 8'hA5});
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
      idle(3);

`ifdef SERIAL_RX_ERROR_COUNT_EN
      // five bad-parity frames saturate a 2-bit counter
      for (int i = 1; i <= 5; i++) begin
         exp_q.push_back({1'b1, 1'b0, 8'h0F});
         send_frame(8'h0F, 1'b1, 1'b1, 1'b0);
         idle(2);
         check("t6_err_cnt", 32'(err_cnt), (i < 3) ? 32'(i) : 32'd3);
      end
`endif

      idle(5);
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
